// File: rtl/rv_mem_bist_if.sv
// rv_mem_bist_if: data-memory request/response bus between the BIST initiator
// and the SRAM driver it stands in front of.
interface rv_mem_bist_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/rv_mem_bist.sv
// rv_mem_bist: writes a Galois LFSR pattern over a word range, reads it back and
// reports the first miscompare. Define RV_MEM_BIST_TIMEOUT_EN for a request watchdog.
module rv_mem_bist #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [31:0]   seed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          timeout_o,
    output logic [31:0]   err_addr_o,
    output logic [31:0]   err_exp_o,
    output logic [31:0]   err_got_o,
    rv_mem_bist_if.master bus
);
    localparam int unsigned CW   = $clog2(WORDS + 1);
    localparam logic [31:0] POLY = 32'h8020_0003;

    if (WORDS < 1 || BASE_ADDR[1:0] != 2'b00 || TIMEOUT < 1) begin : g_bad_param
        $error("rv_mem_bist: WORDS and TIMEOUT must be >= 1 and BASE_ADDR word aligned");
    end

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   seed_q;
    logic [31:0]   seed_init;
    logic [31:0]   lfsr_q;
    logic [31:0]   lfsr_next;
    logic [31:0]   addr;
    logic [CW-1:0] idx_q;
    logic          req_q;
    logic          pass_q;
    logic [31:0]   err_addr_q;
    logic [31:0]   err_exp_q;
    logic [31:0]   err_got_q;
    logic          accept;
    logic          last;
    logic          mismatch;
    logic          tmo_hit;
    logic          start_ok;

    assign seed_init = (seed_i == 32'h0) ? 32'h1 : seed_i;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
    assign addr      = BASE_ADDR + (32'(idx_q) << 2);
    assign accept    = req_q & bus.data_rvalid_i;
    assign last      = (idx_q == CW'(WORDS - 1));
    assign mismatch  = (bus.data_rdata_i != lfsr_q);
    assign start_ok  = start_i & ((state_q == IDLE) | (state_q == DONE));

`ifdef RV_MEM_BIST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_q;

    // Watchdog counts request cycles of the access in flight; the hit fires on
    // the TIMEOUT-th such cycle so the abort lands TIMEOUT cycles after req.
    assign tmo_hit = req_q & ~bus.data_rvalid_i & (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!req_q || bus.data_rvalid_i) tmo_cnt_q <= '0;
            else                             tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (start_ok)     timeout_q <= 1'b0;
            else if (tmo_hit) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        busy_o            = 1'b0;
        done_o            = 1'b0;
        bus.data_req_o    = req_q & ~bus.data_rvalid_i;
        bus.data_we_o     = 1'b0;
        bus.data_be_o     = 4'b1111;
        bus.data_addr_o   = addr;
        bus.data_wdata_o  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = WR;
            end
            WR: begin
                busy_o           = 1'b1;
                bus.data_we_o    = 1'b1;
                bus.data_wdata_o = lfsr_q;
                if (tmo_hit)             state_d = DONE;
                else if (accept && last) state_d = RD;
            end
            RD: begin
                busy_o = 1'b1;
                if (tmo_hit || (accept && (mismatch || last))) state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) state_d = WR;
            end
            default: state_d = IDLE;
        endcase
    end

    // req_q stays high across back-to-back accesses; the rvalid cycle itself
    // provides the one-cycle gap through the combinational mask above.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seed_q     <= 32'h0;
            lfsr_q     <= 32'h0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            pass_q     <= 1'b0;
            err_addr_q <= 32'h0;
            err_exp_q  <= 32'h0;
            err_got_q  <= 32'h0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        seed_q     <= seed_init;
                        lfsr_q     <= seed_init;
                        idx_q      <= '0;
                        req_q      <= 1'b1;
                        pass_q     <= 1'b0;
                        err_addr_q <= 32'h0;
                        err_exp_q  <= 32'h0;
                        err_got_q  <= 32'h0;
                    end
                end
                WR: begin
                    if (tmo_hit) begin
                        req_q      <= 1'b0;
                        err_addr_q <= addr;
                        err_exp_q  <= lfsr_q;
                        err_got_q  <= 32'h0;
                    end else if (accept) begin
                        if (last) begin
                            idx_q  <= '0;
                            lfsr_q <= seed_q;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            lfsr_q <= lfsr_next;
                        end
                    end
                end
                RD: begin
                    if (tmo_hit) begin
                        req_q      <= 1'b0;
                        err_addr_q <= addr;
                        err_exp_q  <= 32'h0;
                        err_got_q  <= 32'h0;
                    end else if (accept) begin
                        if (mismatch) begin
                            req_q      <= 1'b0;
                            pass_q     <= 1'b0;
                            err_addr_q <= addr;
                            err_exp_q  <= lfsr_q;
                            err_got_q  <= bus.data_rdata_i;
                        end else if (last) begin
                            req_q  <= 1'b0;
                            pass_q <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            lfsr_q <= lfsr_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass_o     = pass_q;
    assign err_addr_o = err_addr_q;
    assign err_exp_o  = err_exp_q;
    assign err_got_o  = err_got_q;
endmodule

// File: tb/tb_rv_mem_bist.sv
// tb_rv_mem_bist: randomized responder plus a list-of-accesses reference model
// for rv_mem_bist, with directed cases for seed, miscompare, hang and reset.
`timescale 1ns/1ps
module tb_rv_mem_bist;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned NW   = 4;
    localparam int unsigned TMO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic        busy, done, pass, tmo;
    logic [31:0] err_addr, err_exp, err_got;

    rv_mem_bist_if bus ();

    rv_mem_bist #(.BASE_ADDR(BASE), .WORDS(NW), .TIMEOUT(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .seed_i     (seed),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .timeout_o  (tmo),
        .err_addr_o (err_addr),
        .err_exp_o  (err_exp),
        .err_got_o  (err_got),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Responder configuration
    bit          resp_on;
    int          lat_fixed;
    bit          flip_en;
    logic [31:0] flip_addr;
    logic [31:0] flip_mask;
    logic [31:0] mem [logic [31:0]];

    // Reference model: the expected ordered list of accesses and final result
    logic        exp_we    [$];
    logic [31:0] exp_addr  [$];
    logic [31:0] exp_wdata [$];
    bit          exp_pass;
    logic [31:0] exp_eaddr, exp_eexp, exp_egot;
    int          acc_idx;
    bit          prev_rv;
    bit          mon_on;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] s0, input int i);
        logic [31:0] s;
        s = (s0 == 32'h0) ? 32'h1 : s0;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
    endfunction

    task automatic buildModel(input logic [31:0] s);
        logic [31:0] a, p, got;
        exp_we.delete(); exp_addr.delete(); exp_wdata.delete();
        for (int i = 0; i < int'(NW); i++) begin
            exp_we.push_back(1'b1);
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_wdata.push_back(pattern(s, i));
        end
        exp_pass = 1'b1; exp_eaddr = 32'h0; exp_eexp = 32'h0; exp_egot = 32'h0;
        for (int i = 0; i < int'(NW); i++) begin
            a   = BASE + 32'(4 * i);
            p   = pattern(s, i);
            got = (flip_en && a == flip_addr) ? (p ^ flip_mask) : p;
            exp_we.push_back(1'b0);
            exp_addr.push_back(a);
            exp_wdata.push_back(32'h0);
            if (got != p) begin
                exp_pass = 1'b0; exp_eaddr = a; exp_eexp = p; exp_egot = got;
                break;
            end
        end
    endtask

    // Responder: answers each request after lat request-cycles and backs the data with mem.
    initial begin : responder
        int          cnt;
        int          lat;
        bit          fire;
        logic [31:0] rd;
        cnt = 0; lat = 1; fire = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !resp_on) begin
                cnt = 0; fire = 1'b0;
            end else if (bus.data_req_o) begin
                if (cnt == 0) lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                cnt++;
                if (cnt >= lat) begin fire = 1'b1; cnt = 0; end
            end
            @(posedge clk); #1;
            bus.data_rvalid_i = 1'b0;
            bus.data_rdata_i  = 32'h0;
            if (fire) begin
                fire = 1'b0;
                bus.data_rvalid_i = 1'b1;
                if (bus.data_we_o) begin
                    mem[bus.data_addr_o] = bus.data_wdata_o;
                end else begin
                    rd = mem.exists(bus.data_addr_o) ? mem[bus.data_addr_o] : 32'h0;
                    if (flip_en && bus.data_addr_o == flip_addr) rd = rd ^ flip_mask;
                    bus.data_rdata_i = rd;
                end
            end
        end
    end

    // Compare process: every busy cycle with a live access is checked against the model.
    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_rv) begin
                prev_rv = 1'b0;
                if (acc_idx < exp_addr.size()) begin
                    checkOutput("req_after_rvalid", 32'(bus.data_req_o), 32'd1);
                end else begin
                    checkOutput("done_after_last", 32'(done), 32'd1);
                    checkOutput("busy_after_last", 32'(busy), 32'd0);
                    checkOutput("req_after_last", 32'(bus.data_req_o), 32'd0);
                end
            end
            if (busy && (bus.data_req_o || bus.data_rvalid_i)) begin
                if (acc_idx >= exp_addr.size()) begin
                    checkOutput("extra_access_addr", bus.data_addr_o, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("acc_we", 32'(bus.data_we_o), 32'(exp_we[acc_idx]));
                    checkOutput("acc_addr", bus.data_addr_o, exp_addr[acc_idx]);
                    checkOutput("acc_wdata", bus.data_wdata_o, exp_wdata[acc_idx]);
                    checkOutput("acc_be", 32'(bus.data_be_o), 32'hF);
                    if (bus.data_rvalid_i) begin
                        checkOutput("req_in_rvalid", 32'(bus.data_req_o), 32'd0);
                        acc_idx++;
                        prev_rv = 1'b1;
                    end
                end
            end
        end
    end

    task automatic checkResult(input string tag);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        checkOutput({tag, "_timeout"}, 32'(tmo), 32'd0);
        checkOutput({tag, "_err_addr"}, err_addr, exp_eaddr);
        checkOutput({tag, "_err_exp"}, err_exp, exp_eexp);
        checkOutput({tag, "_err_got"}, err_got, exp_egot);
    endtask

    task automatic applyStimulus(input logic [31:0] s, input bit fen, input logic [31:0] fa,
                                 input logic [31:0] fm, input int glitch_at, input string tag);
        int cyc;
        flip_en = fen; flip_addr = fa; flip_mask = fm;
        buildModel(s);
        @(posedge clk); #1;
        acc_idx = 0; prev_rv = 1'b0; mon_on = 1'b1;
        start = 1'b1; seed = s;
        @(posedge clk); #1;
        start = 1'b0; seed = $urandom;
        @(negedge clk);
        checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_start_req"}, 32'(bus.data_req_o), 32'd1);
        checkOutput({tag, "_start_addr"}, bus.data_addr_o, BASE);
        cyc = 1;
        while (!done && cyc < 500) begin
            @(posedge clk); #1;
            start = (cyc == glitch_at);
            if (start) seed = $urandom;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) checkOutput({tag, "_done_bound"}, 32'(cyc), 32'd499);
        checkResult(tag);
        @(posedge clk); #1;
        mon_on = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int          cyc;
        logic [31:0] a;
        logic [31:0] rs, rm, ra;
        resp_on = 1'b1; lat_fixed = 3; flip_en = 1'b0; flip_addr = 32'h0; flip_mask = 32'h0;
        mon_on = 1'b0; acc_idx = 0; prev_rv = 1'b0;
        rst = 1'b1; start = 1'b0; seed = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_timeout", 32'(tmo), 32'd0);
        checkOutput("rst_err_addr", err_addr, 32'h0);
        checkOutput("rst_err_exp", err_exp, 32'h0);
        checkOutput("rst_err_got", err_got, 32'h0);
        checkOutput("rst_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("rst_we", 32'(bus.data_we_o), 32'd0);
        checkOutput("rst_wdata", bus.data_wdata_o, 32'h0);
        checkOutput("rst_addr", bus.data_addr_o, BASE);
        checkOutput("rst_be", 32'(bus.data_be_o), 32'hF);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] directed: seed 1, fixed latency 3");
        applyStimulus(32'h1, 1'b0, 32'h0, 32'h0, 3, "seed1");
        checkOutput("seed1_pass_lit", 32'(pass), 32'd1);
        a = 32'h0; checkOutput("seed1_mem0", mem[a], 32'h0000_0001);
        a = 32'h4; checkOutput("seed1_mem4", mem[a], 32'h8020_0003);
        a = 32'h8; checkOutput("seed1_mem8", mem[a], 32'hC030_0002);
        a = 32'hC; checkOutput("seed1_memC", mem[a], 32'h6018_0001);

        $display("[TB] directed: bit 0 flipped on read at 0x8");
        applyStimulus(32'h1, 1'b1, 32'h8, 32'h1, 5, "flip8");
        checkOutput("flip8_pass_lit", 32'(pass), 32'd0);
        checkOutput("flip8_addr_lit", err_addr, 32'h8);
        checkOutput("flip8_exp_lit", err_exp, 32'hC030_0002);
        checkOutput("flip8_got_lit", err_got, 32'hC030_0003);

        $display("[TB] directed: seed 0");
        mem.delete();
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 2, "seed0");
        a = 32'h0; checkOutput("seed0_mem0", mem[a], 32'h0000_0001);
        a = 32'h4; checkOutput("seed0_mem4", mem[a], 32'h8020_0003);
        a = 32'h8; checkOutput("seed0_mem8", mem[a], 32'hC030_0002);
        a = 32'hC; checkOutput("seed0_memC", mem[a], 32'h6018_0001);

        $display("[TB] directed: responder never answers");
        resp_on = 1'b0; flip_en = 1'b0;
        buildModel(32'h1);
        @(posedge clk); #1;
        acc_idx = 0; prev_rv = 1'b0; mon_on = 1'b1; start = 1'b1; seed = 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("hang_first_req", 32'(bus.data_req_o), 32'd1);
        repeat (TMO - 1) @(negedge clk);
`ifdef RV_MEM_BIST_TIMEOUT_EN
        checkOutput("hang_tmo_early", 32'(tmo), 32'd0);
        checkOutput("hang_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("hang_timeout", 32'(tmo), 32'd1);
        checkOutput("hang_done", 32'(done), 32'd1);
        checkOutput("hang_pass", 32'(pass), 32'd0);
        checkOutput("hang_busy", 32'(busy), 32'd0);
        checkOutput("hang_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("hang_err_addr", err_addr, BASE);
        checkOutput("hang_err_exp", err_exp, 32'h1);
        checkOutput("hang_err_got", err_got, 32'h0);
`else
        repeat (40) @(negedge clk);
        checkOutput("hang_busy", 32'(busy), 32'd1);
        checkOutput("hang_done", 32'(done), 32'd0);
        checkOutput("hang_timeout", 32'(tmo), 32'd0);
        checkOutput("hang_req", 32'(bus.data_req_o), 32'd1);
`endif
        @(posedge clk); #1;
        mon_on = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; resp_on = 1'b1;

        $display("[TB] directed: reset during third write");
        lat_fixed = 3; flip_en = 1'b0;
        buildModel(32'h1234_5678);
        @(posedge clk); #1;
        acc_idx = 0; prev_rv = 1'b0; mon_on = 1'b1; start = 1'b1; seed = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(acc_idx == 2 && bus.data_req_o) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) checkOutput("rstmid_third_write_bound", 32'(cyc), 32'd99);
        @(posedge clk); #1;
        rst = 1'b1; mon_on = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstmid_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_done", 32'(done), 32'd0);
        checkOutput("rstmid_addr", bus.data_addr_o, BASE);
        rst = 1'b0;
        applyStimulus(32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 4, "after_rst");
        checkOutput("after_rst_pass_lit", 32'(pass), 32'd1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 16; r++) begin
            rs = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            rm = $urandom;
            if (rm == 32'h0) rm = 32'h8000_0000;
            ra = BASE + 32'(4 * $urandom_range(0, NW - 1));
            lat_fixed = int'($urandom_range(0, 3));
            applyStimulus(rs, 1'($urandom_range(0, 1)), ra, rm, int'($urandom_range(1, 6)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
